dram_arb: RTL and testbench



---
 rtl/dram_pkg.sv | 30 +++
 rtl/dram_arb_if.sv | 43 ++++
 rtl/dram_arb_rr_pick.sv | 37 +++
 rtl/dram_arb.sv | 155 +++++++++++++++
 tb/tb_dram_arb.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_pkg.sv
// Shared DRAM arbiter package.
// Holds default bus widths, requester IDs, DRAM region bases, the arbiter
// FSM state type and a small index-width helper used by the arbiter files.
package dram_pkg;

    localparam int DRAM_DATA_WIDTH = 32;
    localparam int DRAM_ADDR_WIDTH = 18;

    // Requester IDs (bit position in req/gnt vectors)
    localparam int REQ_CONV = 0;
    localparam int REQ_POOL = 1;
    localparam int REQ_HOST = 2;

    // DRAM region bases
    localparam int PARAM_BASE  = 0;
    localparam int WEIGHT_BASE = 64;
    localparam int IFMAP_BASE  = 65536;
    localparam int OFMAP_BASE  = 131072;

    typedef enum logic {
        ST_IDLE = 1'b0,   // no owner
        ST_OWN  = 1'b1    // owner registered, its gnt bit is high
    } arb_state_t;

    // Width of an index into n entries; never returns 0 so n == 1 still works.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_arb_if.sv
// DRAM arbiter bus interface.
// Bundles the requester side (req_*, gnt, rdata, rdata_vld) and the DRAM
// side (dram_*) of the arbiter.
//   slave  : arbiter view  - requests and dram_rdata in, grant/DRAM port out
//   master : environment view (requesters + DRAM) - the opposite directions
// Per-requester fields are packed [NREQ-1:0][W-1:0], requester i in slice i.
interface dram_arb_if
    import dram_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int DATA_WIDTH = DRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DRAM_ADDR_WIDTH
);

    logic [NREQ-1:0]                 req_rd;
    logic [NREQ-1:0]                 req_wr;
    logic [NREQ-1:0][ADDR_WIDTH-1:0] req_addr_rd;
    logic [NREQ-1:0][ADDR_WIDTH-1:0] req_addr_wr;
    logic [NREQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]                 gnt;
    logic [DATA_WIDTH-1:0]           rdata;
    logic [NREQ-1:0]                 rdata_vld;

    logic                            dram_en_rd;
    logic                            dram_en_wr;
    logic [ADDR_WIDTH-1:0]           dram_addr_in;
    logic [ADDR_WIDTH-1:0]           dram_addr_out;
    logic [DATA_WIDTH-1:0]           dram_wdata;
    logic [DATA_WIDTH-1:0]           dram_rdata;

    modport slave (
        input  req_rd, req_wr, req_addr_rd, req_addr_wr, req_wdata, dram_rdata,
        output gnt, rdata, rdata_vld,
               dram_en_rd, dram_en_wr, dram_addr_in, dram_addr_out, dram_wdata
    );

    modport master (
        output req_rd, req_wr, req_addr_rd, req_addr_wr, req_wdata, dram_rdata,
        input  gnt, rdata, rdata_vld,
               dram_en_rd, dram_en_wr, dram_addr_in, dram_addr_out, dram_wdata
    );

endinterface

// File: rtl/dram_arb_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Scans active[] starting at last+1 (mod N) and returns the first hit.
//   active : candidate vector
//   last   : index of the previous winner (search starts just after it)
//   oh     : one-hot winner, idx : winner index, valid : any candidate
module rr_pick
    import dram_pkg::*;
#(
    parameter int N = 3,
    localparam int IW = id_width(N)
) (
    input  logic [N-1:0]  active,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  oh,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    always_comb begin
        oh    = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        // k runs 1..N so 'last' itself is checked last
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!valid && active[cand]) begin
                valid     = 1'b1;
                idx       = cand;
                oh[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_arb.sv
// dram_arb: round-robin arbiter giving NREQ requesters (conv, pool, host
// loader) exclusive use of a single DRAM port.
// Ports:
//   clk, srstn : clock, synchronous active-low reset
//   bus        : dram_arb_if.slave - requests in, registered one-hot gnt,
//                combinational DRAM port mux from the owner, broadcast rdata
//                with a one-hot rdata_vld one cycle after each read.
// Build option: DRAM_ARB_BURST_LIMIT_EN - caps an ownership at MAX_BURST
// cycles when someone else is waiting; without it the owner keeps the port
// until it drops its request.
module dram_arb
    import dram_pkg::*;
#(
    parameter int DATA_WIDTH = DRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DRAM_ADDR_WIDTH,
    parameter int NREQ       = 3,
    parameter int MAX_BURST  = 64
) (
    input logic       clk,
    input logic       srstn,
    dram_arb_if.slave bus
);

    localparam int IW = id_width(NREQ);

    arb_state_t      state, state_nxt;
    // In ST_OWN this is the current owner; in ST_IDLE it is the previous one.
    logic [IW-1:0]   last_owner, last_nxt;
    logic [NREQ-1:0] gnt_q, gnt_nxt;
    logic [NREQ-1:0] rd_vld_q;

    logic [NREQ-1:0] active, pick_in, pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic            own, owner_act, preempt, handover, en_ok, en_rd;

    assign active    = bus.req_rd | bus.req_wr;
    assign own       = (state == ST_OWN);
    assign owner_act = own && active[last_owner];

    // While owning, only other requesters compete for the next slot.
    assign pick_in = own ? (active & ~gnt_q) : active;

    rr_pick #(.N(NREQ)) u_pick (
        .active (pick_in),
        .last   (last_owner),
        .oh     (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_vld)
    );

`ifdef DRAM_ARB_BURST_LIMIT_EN
    localparam int CW = id_width(MAX_BURST);
    localparam logic [CW-1:0] BURST_END = CW'(MAX_BURST - 1);

    logic [CW-1:0] burst_cnt;

    // Only cut the owner off when there is a contender to hand over to.
    assign preempt = own && (burst_cnt == BURST_END) && pick_vld;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            burst_cnt <= '0;
        end else if (!own || handover) begin
            burst_cnt <= '0;
        end else if (burst_cnt != BURST_END) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end
`else
    assign preempt = 1'b0;

    // MAX_BURST only matters with the burst limit built in.
    if (MAX_BURST < 1) begin : g_max_burst_unused
    end
`endif

    // Owner gives up the port this cycle (released or preempted).
    assign handover = own && (!owner_act || preempt);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state      <= ST_IDLE;
            last_owner <= IW'(NREQ - 1);
            gnt_q      <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_nxt;
            gnt_q      <= gnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last_owner;
        gnt_nxt   = gnt_q;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nxt = ST_OWN;
                    last_nxt  = pick_idx;
                    gnt_nxt   = pick_oh;
                end
            end
            ST_OWN: begin
                if (handover) begin
                    if (pick_vld) begin
                        last_nxt = pick_idx;
                        gnt_nxt  = pick_oh;
                    end else begin
                        state_nxt = ST_IDLE;
                        gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // DRAM port mux: addresses/data follow the owner, enables only while
    // it still holds its request and is not being preempted.
    // ------------------------------------------------------------------
    assign en_ok = owner_act && !preempt;
    assign en_rd = en_ok && bus.req_rd[last_owner];

    assign bus.dram_en_rd    = en_rd;
    assign bus.dram_en_wr    = en_ok && bus.req_wr[last_owner];
    assign bus.dram_addr_in  = own ? bus.req_addr_rd[last_owner] : '0;
    assign bus.dram_addr_out = own ? bus.req_addr_wr[last_owner] : '0;
    assign bus.dram_wdata    = own ? bus.req_wdata[last_owner]   : '0;

    // ------------------------------------------------------------------
    // Read return: tag the read with the grant vector of the issuing cycle,
    // so the valid lands on the right requester even after a handover.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!srstn) begin
            rd_vld_q <= '0;
        end else begin
            rd_vld_q <= en_rd ? gnt_q : '0;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rdata_vld = rd_vld_q;
    assign bus.rdata     = bus.dram_rdata;

endmodule

// File: tb/tb_dram_arb.sv
// Testbench for dram_arb: directed scenarios followed by random traffic,
// every cycle compared against a behavioural round-robin model.
module tb_dram_arb;
    import dram_pkg::*;

    localparam int DW = 32;
    localparam int AW = 18;
    localparam int NR = 3;
    localparam int MB = 8;
`ifdef DRAM_ARB_BURST_LIMIT_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    logic clk = 1'b0;
    logic srstn = 1'b0;
    always #5 clk = ~clk;

    dram_arb_if #(.NREQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NREQ(NR), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // model: owner index (-1 = none), previous owner, cycles owned, pending read
    int              m_own, m_last, m_cnt;
    logic [NR-1:0]   m_rv;
    logic [AW-1:0]   m_rv_addr;

    logic [NR-1:0]   s_gnt, s_vld;
    logic            s_enwr;
    logic [NR-1:0]   gq[$];
    logic [NR-1:0]   vq[$];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[13:0], a} ^ 32'hC3C3_0F0F;
    endfunction

    // first active requester after 'after' (wrapping), skipping 'excl'
    function automatic int next_from(input int after, input int excl, input logic [NR-1:0] act);
        for (int k = 1; k <= NR; k++) begin
            int c = (after + k) % NR;
            if (c != excl && act[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, advance the model at posedge.
    task automatic tick();
        logic [NR-1:0] act, e_gnt;
        logic          e_rd, e_wr;
        logic [AW-1:0] e_ai, e_ao;
        logic [DW-1:0] e_wd, nxt_rdata;
        int            n;
        bit            on, lim;
        @(negedge clk);
        act = bus.req_rd | bus.req_wr;
        e_gnt = '0; e_rd = 1'b0; e_wr = 1'b0; e_ai = '0; e_ao = '0; e_wd = '0; on = 1'b0;
        if (m_own >= 0) begin
            e_gnt = NR'(1) << m_own;
            on    = act[m_own];
            n     = next_from(m_own, m_own, act);
            e_ai  = bus.req_addr_rd[m_own];
            e_ao  = bus.req_addr_wr[m_own];
            e_wd  = bus.req_wdata[m_own];
        end else begin
            n = next_from(m_last, -1, act);
        end
        lim = BL && (m_own >= 0) && (m_cnt == MB - 1) && (n >= 0);
        if (on && !lim) begin
            e_rd = bus.req_rd[m_own];
            e_wr = bus.req_wr[m_own];
        end
        chk("gnt", bus.gnt, e_gnt);
        chk("en_rd", bus.dram_en_rd, e_rd);
        chk("en_wr", bus.dram_en_wr, e_wr);
        chk("addr_in", bus.dram_addr_in, e_ai);
        chk("addr_out", bus.dram_addr_out, e_ao);
        chk("wdata", bus.dram_wdata, e_wd);
        chk("rdata_vld", bus.rdata_vld, m_rv);
        if (m_rv != '0) chk("rdata", bus.rdata, mem_word(m_rv_addr));
        s_gnt = bus.gnt; s_vld = bus.rdata_vld; s_enwr = bus.dram_en_wr;
        gq.push_back(bus.gnt);
        vq.push_back(bus.rdata_vld);
        nxt_rdata = bus.dram_en_rd ? mem_word(bus.dram_addr_in) : DW'($urandom);
        @(posedge clk);
        if (!srstn) begin
            m_own = -1; m_last = NR - 1; m_cnt = 0; m_rv = '0;
        end else begin
            m_rv = e_rd ? e_gnt : '0;
            m_rv_addr = e_ai;
            if (m_own < 0 || !on || lim) begin
                if (n >= 0) begin
                    m_own = n; m_last = n; m_cnt = 0;
                end else begin
                    m_own = -1;
                end
            end else if (m_cnt < MB - 1) begin
                m_cnt++;
            end
        end
        #1;
        bus.dram_rdata = nxt_rdata;
    endtask

    task automatic do_reset();
        srstn = 1'b0;
        bus.req_rd = '0;
        bus.req_wr = '0;
        tick();
        tick();
        srstn = 1'b1;
    endtask

    initial begin
        int need[NR];
        int k, r, first, lastnz, cnt;
        logic [NR-1:0] prev;
        logic [NR-1:0] ord[$];

        bus.req_rd = '0; bus.req_wr = '0;
        bus.req_addr_rd = '0; bus.req_addr_wr = '0; bus.req_wdata = '0;
        bus.dram_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        m_own = -1; m_last = NR - 1; m_cnt = 0; m_rv = '0; m_rv_addr = '0;

        // reset state
        do_reset();
        chk("rst_gnt", s_gnt, 0);
        chk("rst_vld", s_vld, 0);

        // single read from conv at the ifmap base
        bus.req_addr_rd[REQ_CONV] = AW'(IFMAP_BASE);
        bus.req_rd[REQ_CONV] = 1'b1;
        gq.delete(); vq.delete();
        repeat (3) tick();
        chk("rd1_gnt_c0", gq[0], 0);
        chk("rd1_gnt_c1", gq[1], 3'b001);
        chk("rd1_vld_c2", vq[2], 3'b001);
        bus.req_rd = '0;
        repeat (2) tick();

        // all three from idle, each holds 4 granted cycles
        do_reset();
        need = '{4, 4, 4};
        gq.delete();
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < NR; i++) bus.req_rd[i] = (need[i] > 0);
            tick();
            for (int i = 0; i < NR; i++) if (s_gnt[i] && bus.req_rd[i]) need[i]--;
        end
        prev = '0; first = -1; lastnz = -1; cnt = 0; ord.delete();
        foreach (gq[i]) begin
            if (gq[i] != '0) begin
                if (gq[i] != prev) ord.push_back(gq[i]);
                prev = gq[i];
                if (first < 0) first = i;
                lastnz = i;
                cnt++;
            end
        end
        chk("rr_nowners", ord.size(), 3);
        chk("rr_order0", (ord.size() > 0) ? ord[0] : 3'b000, 3'b001);
        chk("rr_order1", (ord.size() > 1) ? ord[1] : 3'b000, 3'b010);
        chk("rr_order2", (ord.size() > 2) ? ord[2] : 3'b000, 3'b100);
        chk("rr_gnt_cycles", cnt, 15);
        chk("rr_no_gap", lastnz - first + 1, 15);

        // owner 0 reads up to its last cycle, then owner 1 writes
        bus.req_addr_rd[REQ_CONV] = AW'(WEIGHT_BASE);
        bus.req_addr_wr[REQ_POOL] = AW'(OFMAP_BASE + 5);
        bus.req_wdata[REQ_POOL]   = DW'($urandom);
        need = '{3, 2, 0};
        gq.delete(); vq.delete();
        for (int c = 0; c < 12; c++) begin
            bus.req_rd[REQ_CONV] = (need[0] > 0);
            bus.req_wr[REQ_POOL] = (need[1] > 0);
            tick();
            if (s_gnt[0] && bus.req_rd[REQ_CONV]) need[0]--;
            if (s_gnt[1] && bus.req_wr[REQ_POOL]) need[1]--;
        end
        k = -1;
        foreach (gq[i]) if (k < 0 && gq[i] == 3'b010) k = i;
        chk("sw_found", (k > 0) ? 1 : 0, 1);
        chk("sw_vld_prev", (k > 0) ? vq[k-1] : 3'bxxx, 3'b001);
        chk("sw_vld_at", (k > 0) ? vq[k] : 3'bxxx, 3'b000);
        bus.req_rd = '0; bus.req_wr = '0;

        // req0 holds while req1 waits
        do_reset();
        bus.req_rd = 3'b011;
        gq.delete();
        repeat (21) tick();
        r = 0;
        for (int i = 1; i < gq.size() && gq[i] == 3'b001; i++) r++;
        chk("burst_run", r, BL ? 8 : 20);
        chk("burst_gnt9", gq[9], BL ? 3'b010 : 3'b001);
        bus.req_rd = '0;
        tick();

        // reset in the middle of a write burst
        do_reset();
        bus.req_addr_wr[REQ_CONV] = AW'(OFMAP_BASE);
        bus.req_wdata[REQ_CONV]   = DW'($urandom);
        bus.req_wr[REQ_CONV] = 1'b1;
        repeat (3) tick();
        srstn = 1'b0;
        tick();
        srstn = 1'b1;
        bus.req_rd[REQ_POOL] = 1'b1;
        tick();
        chk("mid_rst_gnt", s_gnt, 0);
        chk("mid_rst_enwr", s_enwr, 0);
        tick();
        chk("post_rst_gnt", s_gnt, 3'b001);
        bus.req_rd = '0; bus.req_wr = '0;
        tick();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(3) == 0) bus.req_rd[i] = ~bus.req_rd[i];
                if ($urandom_range(3) == 0) bus.req_wr[i] = ~bus.req_wr[i];
                bus.req_addr_rd[i] = AW'($urandom);
                bus.req_addr_wr[i] = AW'($urandom);
                bus.req_wdata[i]   = DW'($urandom);
            end
            srstn = ($urandom_range(99) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
